// File: rtl/tone_detector_iq.sv
// Quadrature tone analyzer: mixes a sample stream with a reference cos/sin pair and integrates I/Q per window.
// Optional magnitude/detect stage enabled by defining TONE_MAG_EN.
`timescale 1ns/1ps
module tone_detector_iq #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned REF_W  = 16,
  parameter int unsigned N_LOG2 = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_valid,
  input  logic [DATA_W-1:0]               i_sample,
  input  logic [REF_W-1:0]                i_cos,
  input  logic [REF_W-1:0]                i_sin,
  input  logic                            i_clear,
  input  logic [DATA_W+REF_W+N_LOG2:0]    i_thresh,
  output logic [DATA_W+REF_W+N_LOG2-1:0]  o_i,
  output logic [DATA_W+REF_W+N_LOG2-1:0]  o_q,
  output logic                            o_valid,
  output logic [DATA_W+REF_W+N_LOG2:0]    o_mag,
  output logic                            o_mag_valid,
  output logic                            o_detect
);

  localparam int unsigned PROD_W = DATA_W + REF_W;
  localparam int unsigned ACC_W  = DATA_W + REF_W + N_LOG2;
  localparam int unsigned MAG_W  = ACC_W + 1;
  localparam int unsigned WIN    = 1 << N_LOG2;

  logic signed [PROD_W-1:0] w_prod_i;
  logic signed [PROD_W-1:0] w_prod_q;
  logic                     w_dump;

  logic [N_LOG2-1:0]        r_cnt;
  logic                     r_v1;
  logic                     r_last1;
  logic signed [PROD_W-1:0] r_prod_i;
  logic signed [PROD_W-1:0] r_prod_q;
  logic signed [ACC_W-1:0]  r_acc_i;
  logic signed [ACC_W-1:0]  r_acc_q;
  logic signed [ACC_W-1:0]  r_o_i;
  logic signed [ACC_W-1:0]  r_o_q;
  logic                     r_o_valid;

  assign w_prod_i = PROD_W'($signed(i_sample)) * PROD_W'($signed(i_cos));
  assign w_prod_q = PROD_W'($signed(i_sample)) * PROD_W'($signed(i_sin));
  assign w_dump   = r_v1 && r_last1;

  // Stage 1: multiply and window position; a sample presented with i_clear is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_v1     <= 1'b0;
      r_last1  <= 1'b0;
      r_prod_i <= '0;
      r_prod_q <= '0;
    end else if (i_clear) begin
      r_cnt   <= '0;
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
    end else begin
      r_v1    <= i_valid;
      r_last1 <= i_valid && (r_cnt == N_LOG2'(WIN - 1));
      if (i_valid) begin
        r_prod_i <= w_prod_i;
        r_prod_q <= w_prod_q;
        r_cnt    <= r_cnt + N_LOG2'(1);
      end
    end
  end

  // Stage 2: integrate; a dump already in flight completes even under i_clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_i   <= '0;
      r_acc_q   <= '0;
      r_o_i     <= '0;
      r_o_q     <= '0;
      r_o_valid <= 1'b0;
    end else begin
      r_o_valid <= w_dump;
      if (w_dump) begin
        r_o_i <= r_acc_i + ACC_W'(r_prod_i);
        r_o_q <= r_acc_q + ACC_W'(r_prod_q);
      end
      if (i_clear || w_dump) begin
        r_acc_i <= '0;
        r_acc_q <= '0;
      end else if (r_v1) begin
        r_acc_i <= r_acc_i + ACC_W'(r_prod_i);
        r_acc_q <= r_acc_q + ACC_W'(r_prod_q);
      end
    end
  end

  assign o_i     = r_o_i;
  assign o_q     = r_o_q;
  assign o_valid = r_o_valid;

`ifdef TONE_MAG_EN
  logic [MAG_W-1:0] w_i_ext;
  logic [MAG_W-1:0] w_q_ext;
  logic [MAG_W-1:0] w_abs_i;
  logic [MAG_W-1:0] w_abs_q;
  logic [MAG_W-1:0] w_max;
  logic [MAG_W-1:0] w_min;
  logic [MAG_W-1:0] w_mag;
  logic [MAG_W-1:0] r_mag;
  logic             r_mag_valid;
  logic             r_detect;

  // Absolute values are one bit wider so the most-negative sum does not wrap.
  assign w_i_ext = {r_o_i[ACC_W-1], r_o_i};
  assign w_q_ext = {r_o_q[ACC_W-1], r_o_q};
  assign w_abs_i = r_o_i[ACC_W-1] ? MAG_W'(-w_i_ext) : w_i_ext;
  assign w_abs_q = r_o_q[ACC_W-1] ? MAG_W'(-w_q_ext) : w_q_ext;
  assign w_max   = (w_abs_i >= w_abs_q) ? w_abs_i : w_abs_q;
  assign w_min   = (w_abs_i >= w_abs_q) ? w_abs_q : w_abs_i;
  assign w_mag   = w_max + (w_min >> 1);

  // Stage 3: alpha-max-beta-min magnitude and threshold compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag       <= '0;
      r_mag_valid <= 1'b0;
      r_detect    <= 1'b0;
    end else begin
      r_mag_valid <= r_o_valid;
      if (r_o_valid) begin
        r_mag    <= w_mag;
        r_detect <= (w_mag >= i_thresh);
      end
    end
  end

  assign o_mag       = r_mag;
  assign o_mag_valid = r_mag_valid;
  assign o_detect    = r_detect;
`else
  logic w_unused_thresh;

  assign w_unused_thresh = ^i_thresh;
  assign o_mag           = '0;
  assign o_mag_valid     = 1'b0;
  assign o_detect        = 1'b0;
`endif

endmodule

// File: tb/tb_tone_detector_iq.sv
// Directed bench for tone_detector_iq with a 4-sample window.
`timescale 1ns/1ps
module tb_tone_detector_iq;

  localparam int unsigned DATA_W = 18;
  localparam int unsigned REF_W  = 16;
  localparam int unsigned N_LOG2 = 2;
  localparam int unsigned ACC_W  = DATA_W + REF_W + N_LOG2;

  logic                clk;
  logic                rst;
  logic                i_valid;
  logic [DATA_W-1:0]   i_sample;
  logic [REF_W-1:0]    i_cos;
  logic [REF_W-1:0]    i_sin;
  logic                i_clear;
  logic [ACC_W:0]      i_thresh;
  logic [ACC_W-1:0]    o_i;
  logic [ACC_W-1:0]    o_q;
  logic                o_valid;
  logic [ACC_W:0]      o_mag;
  logic                o_mag_valid;
  logic                o_detect;

  int passed;
  int total;
  int pulses;

  logic [ACC_W-1:0] pos30;
  logic [ACC_W-1:0] neg30;
  logic [ACC_W-1:0] neg29;
  logic [ACC_W:0]   mag125;

  tone_detector_iq #(.DATA_W(DATA_W), .REF_W(REF_W), .N_LOG2(N_LOG2)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_sample(i_sample), .i_cos(i_cos),
    .i_sin(i_sin), .i_clear(i_clear), .i_thresh(i_thresh), .o_i(o_i), .o_q(o_q),
    .o_valid(o_valid), .o_mag(o_mag), .o_mag_valid(o_mag_valid), .o_detect(o_detect)
  );

  initial clk = 1'b0;
  always #41.665 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (o_valid === 1'b1) pulses = pulses + 1;
  end

  task automatic drive(input logic v, input logic [DATA_W-1:0] s, input logic [REF_W-1:0] c,
                       input logic [REF_W-1:0] sn, input logic clr);
    i_valid  = v;
    i_sample = s;
    i_cos    = c;
    i_sin    = sn;
    i_clear  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    int p0;
    rst = 1'b1;
    repeat (3) idle();
    total++;
    if ({o_i, o_q, o_valid, o_mag, o_mag_valid, o_detect} !== '0)
      $display("FAIL reset_outputs o_i=%h o_q=%h o_valid=%b o_mag=%h mv=%b det=%b required all 0",
               o_i, o_q, o_valid, o_mag, o_mag_valid, o_detect);
    else passed++;
    rst = 1'b0;
    p0 = pulses;
    repeat (8) idle();
    total++;
    if (pulses - p0 !== 0) $display("FAIL idle_no_pulse pulses=%0d required 0", pulses - p0);
    else passed++;
  endtask

  task automatic test_window();
    for (int k = 0; k < 4; k++) drive(1'b1, 18'd16384, 16'd16384, 16'd0, 1'b0);
    total++;
    if (o_valid !== 1'b0) $display("FAIL win_early_valid o_valid=%b required 0", o_valid);
    else passed++;
    idle();
    total++;
    if (o_valid !== 1'b1) $display("FAIL win_valid o_valid=%b required 1", o_valid);
    else passed++;
    total++;
    if (o_i !== pos30 || o_q !== '0) $display("FAIL win_iq o_i=%h o_q=%h required %h 0", o_i, o_q, pos30);
    else passed++;
    idle();
    total++;
    if (o_valid !== 1'b0 || o_i !== pos30) $display("FAIL win_hold o_valid=%b o_i=%h required 0 %h", o_valid, o_i, pos30);
    else passed++;
  endtask

  task automatic test_gaps();
    int p0;
    p0 = pulses;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 18'h3C000, 16'd0, 16'd16384, 1'b0);
      idle();
      if (k == 3 || k == 7) begin
        total++;
        if (o_valid !== 1'b1 || o_q !== neg30 || o_i !== '0)
          $display("FAIL gap_dump%0d o_valid=%b o_i=%h o_q=%h required 1 0 %h", k, o_valid, o_i, o_q, neg30);
        else passed++;
      end
      if (k == 1) begin
        total++;
        if (o_valid !== 1'b0) $display("FAIL gap_short o_valid=%b required 0", o_valid);
        else passed++;
      end
    end
    idle();
    total++;
    if (pulses - p0 !== 2) $display("FAIL gap_count pulses=%0d required 2", pulses - p0);
    else passed++;
  endtask

  task automatic test_clear();
    int p0;
    p0 = pulses;
    drive(1'b1, 18'd16384, 16'd16384, 16'd0, 1'b0);
    drive(1'b1, 18'd16384, 16'd16384, 16'd0, 1'b0);
    drive(1'b1, 18'd16384, 16'd16384, 16'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 18'd16384, 16'd16384, 16'd0, 1'b0);
      total++;
      if (o_valid !== 1'b0) $display("FAIL clear_early%0d o_valid=%b required 0", k, o_valid);
      else passed++;
    end
    idle();
    total++;
    if (o_valid !== 1'b1 || o_i !== pos30 || o_q !== '0)
      $display("FAIL clear_dump o_valid=%b o_i=%h o_q=%h required 1 %h 0", o_valid, o_i, o_q, pos30);
    else passed++;
    idle();
    total++;
    if (pulses - p0 !== 1) $display("FAIL clear_count pulses=%0d required 1", pulses - p0);
    else passed++;
  endtask

  task automatic test_mag();
    for (int pass_n = 0; pass_n < 2; pass_n++) begin
      i_thresh = (pass_n == 0) ? mag125 : mag125 + 37'd1;
      for (int k = 0; k < 4; k++) drive(1'b1, 18'd16384, 16'd16384, 16'hE000, 1'b0);
      idle();
      total++;
      if (o_valid !== 1'b1 || o_i !== pos30 || o_q !== neg29 || o_mag_valid !== 1'b0)
        $display("FAIL mag_dump%0d o_valid=%b o_i=%h o_q=%h mv=%b required 1 %h %h 0",
                 pass_n, o_valid, o_i, o_q, o_mag_valid, pos30, neg29);
      else passed++;
      idle();
`ifdef TONE_MAG_EN
      total++;
      if (o_mag_valid !== 1'b1 || o_mag !== mag125 || o_detect !== (pass_n == 0))
        $display("FAIL mag_value%0d mv=%b o_mag=%h det=%b required 1 %h %b",
                 pass_n, o_mag_valid, o_mag, o_detect, mag125, (pass_n == 0));
      else passed++;
`else
      total++;
      if (o_mag_valid !== 1'b0 || o_mag !== '0 || o_detect !== 1'b0)
        $display("FAIL mag_off%0d mv=%b o_mag=%h det=%b required 0 0 0", pass_n, o_mag_valid, o_mag, o_detect);
      else passed++;
`endif
    end
  endtask

  task automatic test_rst_mid();
    int p0;
    p0 = pulses;
    for (int k = 0; k < 3; k++) drive(1'b1, 18'd16384, 16'd16384, 16'd0, 1'b0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    total++;
    if (o_i !== '0 || o_q !== '0 || o_valid !== 1'b0)
      $display("FAIL rst_mid_out o_i=%h o_q=%h o_valid=%b required 0 0 0", o_i, o_q, o_valid);
    else passed++;
    idle();
    idle();
    total++;
    if (pulses - p0 !== 0) $display("FAIL rst_mid_pulse pulses=%0d required 0", pulses - p0);
    else passed++;
    for (int k = 0; k < 4; k++) drive(1'b1, 18'd16384, 16'd16384, 16'd0, 1'b0);
    idle();
    total++;
    if (o_valid !== 1'b1 || o_i !== pos30 || o_q !== '0)
      $display("FAIL rst_mid_dump o_valid=%b o_i=%h o_q=%h required 1 %h 0", o_valid, o_i, o_q, pos30);
    else passed++;
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    pulses   = 0;
    pos30    = 36'h0_4000_0000;
    neg30    = 36'hF_C000_0000;
    neg29    = 36'hF_E000_0000;
    mag125   = 37'h00_5000_0000;
    rst      = 1'b1;
    i_valid  = 1'b0;
    i_sample = '0;
    i_cos    = '0;
    i_sin    = '0;
    i_clear  = 1'b0;
    i_thresh = '0;
    test_reset();
    test_window();
    test_gaps();
    test_clear();
    test_mag();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
